// File: rtl/phased_burst_transmitter.sv
// Steerable ultrasonic burst engine: one shared multiplier computes a delay per
// channel, then every channel emits BURST_CYCLES carrier periods after its delay.
module phased_burst_transmitter #(
    parameter int NUM_TRANSMITTERS = 4,
    parameter int SIN_WIDTH        = 17,
    parameter int DELAY_PER_TX     = 2623,
    parameter int DELAY_WIDTH      = 16,
    parameter int HALF_PERIOD      = 1250,
    parameter int BURST_CYCLES     = 20,
    parameter int PERIOD_CYCLES    = 16777216
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start,
    input  logic                        repeat_en,
    input  logic                        abort,
    input  logic [SIN_WIDTH-1:0]        sin_value,
    input  logic                        sign_bit,
    output logic [NUM_TRANSMITTERS-1:0] tx_out,
    output logic                        burst_start,
    output logic                        tx_active,
    output logic                        busy
);
    localparam int N         = NUM_TRANSMITTERS;
    localparam int IDX_W     = $clog2(N);
    localparam int DPT_W     = $clog2(DELAY_PER_TX + 1);
    localparam int RAW_W     = DPT_W + IDX_W + SIN_WIDTH;
    localparam int PROD_W    = (RAW_W > DELAY_WIDTH) ? RAW_W : DELAY_WIDTH + 1;
    localparam int T_W       = $clog2(PERIOD_CYCLES);
    localparam int CMP_W     = ((T_W > DELAY_WIDTH) ? T_W : DELAY_WIDTH) + 1;
    localparam int BURST_LEN = 2 * HALF_PERIOD * BURST_CYCLES;
    localparam int PH_LAST   = 2 * HALF_PERIOD - 1;
    localparam int PH_W      = $clog2(2 * HALF_PERIOD);
    localparam int NP_W      = $clog2(BURST_CYCLES + 1);
    localparam int GAP_LAST  = PERIOD_CYCLES - N - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                 state_r;
    logic [SIN_WIDTH-1:0]   sin_r;
    logic                   sign_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DELAY_WIDTH-1:0] off_r [N];
    logic [DELAY_WIDTH-1:0] max_off_r;
    logic [T_W-1:0]         t_r;
    logic [PH_W-1:0]        ph_r [N];
    logic [NP_W-1:0]        np_r [N];
    logic [N-1:0]           run_r;
    logic [N-1:0]           tx_r;
    logic                   burst_start_r;
    logic                   tx_active_r;
    logic                   busy_r;

    logic [IDX_W-1:0]       m_s;
    logic [PROD_W-1:0]      prod_s;
    logic [PROD_W-1:0]      scaled_s;
    logic [DELAY_WIDTH-1:0] calc_off_s;
    logic [T_W-1:0]         t_inc_s;
    logic                   calc_last_s;
    logic                   burst_end_s;
    logic                   gap_end_s;
    logic                   enter_burst_s;
    logic                   cont_burst_s;
    logic [DELAY_WIDTH-1:0] off_now_s [N];
    logic [PH_W-1:0]        ph_nx_s [N];
    logic [NP_W-1:0]        np_nx_s [N];
    logic [N-1:0]           run_nx_s;
    logic [N-1:0]           tx_nx_s;

    function automatic logic [DELAY_WIDTH-1:0] saturate_delay(input logic [PROD_W-1:0] v);
        logic [PROD_W-1:0] lim;
        lim = {{(PROD_W - DELAY_WIDTH){1'b0}}, {DELAY_WIDTH{1'b1}}};
        if (v > lim) begin
            saturate_delay = {DELAY_WIDTH{1'b1}};
        end else begin
            saturate_delay = v[DELAY_WIDTH-1:0];
        end
    endfunction

    // Shared delay multiplier: full-width product, truncating scale, then saturate.
    always_comb begin
        m_s        = sign_r ? (IDX_W'(N - 1) - idx_r) : idx_r;
        prod_s     = PROD_W'(DELAY_PER_TX) * PROD_W'(m_s) * PROD_W'(sin_r);
        scaled_s   = prod_s >> (SIN_WIDTH - 1);
        calc_off_s = saturate_delay(scaled_s);
    end

    // Sequencing conditions derived from the current state and burst counter.
    always_comb begin
        t_inc_s       = t_r + T_W'(1);
        calc_last_s   = (state_r == S_CALC) && (idx_r == IDX_W'(N - 1));
        burst_end_s   = (state_r == S_BURST) &&
                        (CMP_W'(t_r) == CMP_W'(max_off_r) + CMP_W'(BURST_LEN - 1));
        gap_end_s     = (state_r == S_GAP) && (t_r == T_W'(GAP_LAST));
        enter_burst_s = calc_last_s && !abort;
        cont_burst_s  = (state_r == S_BURST) && !burst_end_s && !abort;
    end

    // Next drive per channel; the last offset is still in flight on burst entry.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            ph_nx_s[k]   = ph_r[k];
            np_nx_s[k]   = np_r[k];
            run_nx_s[k]  = run_r[k];
            tx_nx_s[k]   = 1'b0;
            off_now_s[k] = (idx_r == IDX_W'(k)) ? calc_off_s : off_r[k];
            if (enter_burst_s) begin
                run_nx_s[k] = (off_now_s[k] == {DELAY_WIDTH{1'b0}});
                ph_nx_s[k]  = {PH_W{1'b0}};
                np_nx_s[k]  = {NP_W{1'b0}};
                tx_nx_s[k]  = run_nx_s[k];
            end else if (cont_burst_s) begin
                if (!run_r[k]) begin
                    if (CMP_W'(t_inc_s) == CMP_W'(off_r[k])) begin
                        run_nx_s[k] = 1'b1;
                        ph_nx_s[k]  = {PH_W{1'b0}};
                        np_nx_s[k]  = {NP_W{1'b0}};
                        tx_nx_s[k]  = 1'b1;
                    end else begin
                        run_nx_s[k] = 1'b0;
                    end
                end else if (np_r[k] < NP_W'(BURST_CYCLES)) begin
                    if (ph_r[k] == PH_W'(PH_LAST)) begin
                        ph_nx_s[k] = {PH_W{1'b0}};
                        np_nx_s[k] = np_r[k] + NP_W'(1);
                    end else begin
                        ph_nx_s[k] = ph_r[k] + PH_W'(1);
                    end
                    tx_nx_s[k] = (np_nx_s[k] < NP_W'(BURST_CYCLES)) &&
                                 (ph_nx_s[k] < PH_W'(HALF_PERIOD));
                end else begin
                    tx_nx_s[k] = 1'b0;
                end
            end else begin
                run_nx_s[k] = 1'b0;
                ph_nx_s[k]  = {PH_W{1'b0}};
                np_nx_s[k]  = {NP_W{1'b0}};
            end
        end
    end

    // Channel phase trackers and the registered transducer drive.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < N; k++) begin
                ph_r[k] <= {PH_W{1'b0}};
                np_r[k] <= {NP_W{1'b0}};
            end
            run_r <= {N{1'b0}};
            tx_r  <= {N{1'b0}};
        end else begin
            for (int k = 0; k < N; k++) begin
                ph_r[k] <= ph_nx_s[k];
                np_r[k] <= np_nx_s[k];
            end
            run_r <= run_nx_s;
            tx_r  <= tx_nx_s;
        end
    end

    // Main FSM: angle latch, per-channel delay calculation, burst and repeat gap.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r       <= S_IDLE;
            sin_r         <= {SIN_WIDTH{1'b0}};
            sign_r        <= 1'b0;
            idx_r         <= {IDX_W{1'b0}};
            max_off_r     <= {DELAY_WIDTH{1'b0}};
            t_r           <= {T_W{1'b0}};
            burst_start_r <= 1'b0;
            tx_active_r   <= 1'b0;
            busy_r        <= 1'b0;
            for (int k = 0; k < N; k++) begin
                off_r[k] <= {DELAY_WIDTH{1'b0}};
            end
        end else if (abort) begin
            state_r       <= S_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            t_r           <= {T_W{1'b0}};
            burst_start_r <= 1'b0;
            tx_active_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    burst_start_r <= 1'b0;
                    tx_active_r   <= 1'b0;
                    if (start) begin
                        sin_r     <= sin_value;
                        sign_r    <= sign_bit;
                        idx_r     <= {IDX_W{1'b0}};
                        max_off_r <= {DELAY_WIDTH{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= S_CALC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_CALC: begin
                    off_r[idx_r] <= calc_off_s;
                    if (calc_off_s > max_off_r) begin
                        max_off_r <= calc_off_s;
                    end
                    if (calc_last_s) begin
                        state_r       <= S_BURST;
                        t_r           <= {T_W{1'b0}};
                        burst_start_r <= 1'b1;
                        tx_active_r   <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                S_BURST: begin
                    burst_start_r <= 1'b0;
                    t_r           <= t_inc_s;
                    if (burst_end_s) begin
                        tx_active_r <= 1'b0;
                        if (repeat_en) begin
                            state_r <= S_GAP;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    t_r <= t_inc_s;
                    if (gap_end_s) begin
                        if (repeat_en) begin
                            sin_r     <= sin_value;
                            sign_r    <= sign_bit;
                            idx_r     <= {IDX_W{1'b0}};
                            max_off_r <= {DELAY_WIDTH{1'b0}};
                            state_r   <= S_CALC;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    burst_start_r <= 1'b0;
                    tx_active_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out      = tx_r;
    assign burst_start = burst_start_r;
    assign tx_active   = tx_active_r;
    assign busy        = busy_r;
endmodule

// File: tb/tb_phased_burst_transmitter.sv
// Directed bench: a full-width instance and a DELAY_WIDTH=5 instance share stimulus
// and are compared every burst cycle against a per-cycle drive model.
module tb_phased_burst_transmitter;
    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int DPT = 8;
    localparam int HP  = 5;
    localparam int BC  = 3;
    localparam int PER = 200;

    typedef struct {
        logic [7:0]      sin;
        logic            sign;
        logic [3:0][7:0] om;
        logic [3:0][7:0] os;
        int              em;
        int              es;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       start;
    logic       repeat_en;
    logic       abort;
    logic [7:0] sin_value;
    logic       sign_bit;
    logic [3:0] tx_a, tx_b;
    logic       bs_a, bs_b, act_a, act_b, busy_a, busy_b;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [6];

    always #5 clk = ~clk;

    phased_burst_transmitter #(
        .NUM_TRANSMITTERS(N), .SIN_WIDTH(SW), .DELAY_PER_TX(DPT), .DELAY_WIDTH(16),
        .HALF_PERIOD(HP), .BURST_CYCLES(BC), .PERIOD_CYCLES(PER)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .start(start), .repeat_en(repeat_en),
        .abort(abort), .sin_value(sin_value), .sign_bit(sign_bit), .tx_out(tx_a),
        .burst_start(bs_a), .tx_active(act_a), .busy(busy_a)
    );

    phased_burst_transmitter #(
        .NUM_TRANSMITTERS(N), .SIN_WIDTH(SW), .DELAY_PER_TX(DPT), .DELAY_WIDTH(5),
        .HALF_PERIOD(HP), .BURST_CYCLES(BC), .PERIOD_CYCLES(PER)
    ) dut_sat (
        .clk_in(clk), .rst_in(rst_in), .start(start), .repeat_en(repeat_en),
        .abort(abort), .sin_value(sin_value), .sign_bit(sign_bit), .tx_out(tx_b),
        .burst_start(bs_b), .tx_active(act_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_tx(input logic [3:0][7:0] off, input int t);
        logic [3:0] r;
        int d;
        r = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            d = t - int'(off[k]);
            r[k] = (d >= 0) && (d < 2 * HP * BC) && ((d % (2 * HP)) < HP);
        end
        return r;
    endfunction

    // Pulse start in the current cycle; returns in the cycle where t = 0.
    task automatic run_start(input logic [7:0] s, input logic sg);
        sin_value = s;
        sign_bit  = sg;
        chk("idle_busy", {30'd0, busy_a, busy_b}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("calc_first", {28'd0, busy_a, busy_b, bs_a, bs_b}, 32'hC);
        tick();
        tick();
        tick();
        chk("calc_last", {28'd0, busy_a, busy_b, bs_a, bs_b}, 32'hC);
        tick();
    endtask

    task automatic check_burst(input logic [3:0][7:0] om, input logic [3:0][7:0] os,
                               input int em, input int es, input bit gap_after);
        int lim;
        lim = ((em > es) ? em : es) + 1;
        for (int t = 0; t <= lim; t++) begin
            chk($sformatf("tx t=%0d", t), {28'd0, tx_a}, {28'd0, model_tx(om, t)});
            chk($sformatf("tx_sat t=%0d", t), {28'd0, tx_b}, {28'd0, model_tx(os, t)});
            chk($sformatf("ctl t=%0d", t), {29'd0, bs_a, act_a, busy_a},
                {29'd0, t == 0, t <= em, (t <= em) || gap_after});
            chk($sformatf("ctl_sat t=%0d", t), {29'd0, bs_b, act_b, busy_b},
                {29'd0, t == 0, t <= es, (t <= es) || gap_after});
            if (t < lim) tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        tbl[0] = '{8'd64,  1'b0, {8'd12, 8'd8,  8'd4,  8'd0}, {8'd12, 8'd8,  8'd4,  8'd0}, 41, 41};
        tbl[1] = '{8'd64,  1'b1, {8'd0,  8'd4,  8'd8,  8'd12}, {8'd0,  8'd4,  8'd8,  8'd12}, 41, 41};
        tbl[2] = '{8'd0,   1'b0, {8'd0,  8'd0,  8'd0,  8'd0}, {8'd0,  8'd0,  8'd0,  8'd0}, 29, 29};
        tbl[3] = '{8'd255, 1'b0, {8'd47, 8'd31, 8'd15, 8'd0}, {8'd31, 8'd31, 8'd15, 8'd0}, 76, 60};
        tbl[4] = '{8'd128, 1'b1, {8'd0,  8'd8,  8'd16, 8'd24}, {8'd0,  8'd8,  8'd16, 8'd24}, 53, 53};
        tbl[5] = '{8'd100, 1'b0, {8'd18, 8'd12, 8'd6,  8'd0}, {8'd18, 8'd12, 8'd6,  8'd0}, 47, 47};

        if (!(PER > DPT * (N - 1) + 2 * HP * BC + N + 1)) begin
            $display("FAIL config: PERIOD_CYCLES too small for the burst");
            $fatal(1, "config");
        end

        rst_in    = 1'b0;
        start     = 1'b0;
        repeat_en = 1'b0;
        abort     = 1'b0;
        sin_value = 8'd0;
        sign_bit  = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {16'd0, tx_a, tx_b, bs_a, bs_b, act_a, act_b, busy_a, busy_b}, 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_start(tbl[i].sin, tbl[i].sign);
            check_burst(tbl[i].om, tbl[i].os, tbl[i].em, tbl[i].es, 1'b0);
            tick();
        end

        // Repeat mode: new angle presented mid-burst is picked up by the next burst.
        repeat_en = 1'b1;
        run_start(8'd64, 1'b0);
        sin_value = 8'd32;
        check_burst(tbl[0].om, tbl[0].os, 41, 41, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bs_a && n < 400);
        chk("repeat_spacing", 32'(42 + n), 32'd200);
        chk("repeat_start_sat", {31'd0, bs_b}, 32'd1);
        repeat_en = 1'b0;
        check_burst({8'd6, 8'd4, 8'd2, 8'd0}, {8'd6, 8'd4, 8'd2, 8'd0}, 35, 35, 1'b0);
        cnt = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bs_a || bs_b || busy_a || busy_b) cnt++;
        end
        chk("no_refire", 32'(cnt), 32'd0);

        // Abort at t=7 together with a start that must be ignored.
        run_start(8'd64, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("pre_abort_tx", {28'd0, tx_a}, {28'd0, model_tx(tbl[0].om, 7)});
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_outputs", {16'd0, tx_a, tx_b, bs_a, bs_b, act_a, act_b, busy_a, busy_b}, 32'd0);
        tick();
        chk("abort_start_ignored", {30'd0, busy_a, busy_b}, 32'd0);

        // Asynchronous reset mid-burst, then a clean restart.
        run_start(8'd64, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_tx", {28'd0, tx_a}, {28'd0, model_tx(tbl[0].om, 10)});
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_reset", {16'd0, tx_a, tx_b, bs_a, bs_b, act_a, act_b, busy_a, busy_b}, 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        tick();
        chk("post_reset_idle", {30'd0, busy_a, busy_b}, 32'd0);
        run_start(tbl[0].sin, tbl[0].sign);
        check_burst(tbl[0].om, tbl[0].os, tbl[0].em, tbl[0].es, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/phased_burst_transmitter.md
# phased_burst_transmitter

Burst-gated, steerable ultrasonic transmit engine for the Sonic Sight array. The block latches a steering angle (sine magnitude plus direction) and computes one delay per channel on a single shared multiplier. It then drives NUM_TRANSMITTERS square-wave channels for exactly BURST_CYCLES carrier periods each, every PERIOD_CYCLES clocks. It sits between the angle sweep controller and the transducer drivers, and emits a burst_start reference pulse for the receive path.

## Interface
- NUM_TRANSMITTERS, 4: channel count, ≥2; channel 0 is leftmost.
- SIN_WIDTH, 17: sin_value width; unsigned, full scale 1.0 = 2^(SIN_WIDTH-1).
- DELAY_PER_TX, 2623: inter-element delay at sin = 1.0, in clocks.
- DELAY_WIDTH, 16: per-channel offset width; computed offsets saturate to 2^DELAY_WIDTH-1.
- HALF_PERIOD, 1250: carrier half period in clocks (40 kHz at 100 MHz).
- BURST_CYCLES, 20: carrier periods per channel per burst.
- PERIOD_CYCLES, 16777216: burst_start spacing in repeat mode, in clocks.
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin; honoured only in IDLE.
- repeat_en  input  1  sampled at period end; 1 = re-fire with a freshly latched angle.
- abort  input  1  synchronous kill; has priority over all other inputs except reset.
- sin_value  input  SIN_WIDTH  |sin(angle)|.
- sign_bit  input  1  1 = steer left (rightmost channel fires first); 0 = steer right.
- tx_out  output  NUM_TRANSMITTERS  transducer drive.
- burst_start  output  1  one-cycle pulse in the first BURST cycle.
- tx_active  output  1  high throughout BURST.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, CALC, BURST, GAP.
- IDLE → CALC on start. The block latches sin_value and sign_bit on that edge. Later changes to either input have no effect until the next latch.
- CALC lasts exactly NUM_TRANSMITTERS cycles and computes one channel per cycle.
  - m_k = sign_bit ? (N-1-k) : k.
  - off_k = (DELAY_PER_TX·m_k·sin) >> (SIN_WIDTH-1), truncated, then saturated to DELAY_WIDTH.
  - The block also tracks max_off.
  - Intermediate products use full width, with no overflow before saturation.
- CALC → BURST. The burst counter t = 0 in the first BURST cycle, and t increments every cycle through BURST and GAP.
- Channel k drive pattern:
  - tx_out[k] = 1 when t ∈ [off_k + 2·HALF_PERIOD·j, off_k + 2·HALF_PERIOD·j + HALF_PERIOD − 1] for j = 0..BURST_CYCLES−1.
  - tx_out[k] = 0 otherwise.
  - Every channel emits exactly BURST_CYCLES full periods; no partial pulses.
- BURST ends after the cycle t = max_off + 2·HALF_PERIOD·BURST_CYCLES − 1. The block then enters GAP if repeat_en = 1, else IDLE.
- In GAP, at t = PERIOD_CYCLES − NUM_TRANSMITTERS − 1:
  - if repeat_en = 1: re-latch sin_value and sign_bit, then go to CALC, giving a burst_start spacing of exactly PERIOD_CYCLES;
  - else go to IDLE.
- abort in any state: all outputs are 0 and the state is IDLE on the next cycle. A start arriving in the same cycle as abort is ignored.
- A start outside IDLE is ignored.
- Required configuration: PERIOD_CYCLES > DELAY_PER_TX·(N−1) + 2·HALF_PERIOD·BURST_CYCLES + N + 1. The bench asserts this.

## Timing
- Reset: state IDLE; tx_out, burst_start, tx_active and busy all 0; latched angle and offsets 0. Reset asserted mid-burst forces tx_out to 0 asynchronously.
- start high in cycle c:
  - busy = 1 from cycle c+1;
  - CALC spans cycles c+1..c+N;
  - burst_start = 1 and t = 0 in cycle c+N+1.
- All outputs are registered, with no combinational path from inputs to outputs. tx_out is glitch-free.
- When sin = 0, all channels are in phase and max_off = 0.
- burst_start and tx_active rise in the same cycle. tx_active falls in the cycle after the last BURST cycle.
- busy falls the cycle after the IDLE transition.

## Test plan
Common configuration for all tests: N=4, SIN_WIDTH=8, DELAY_PER_TX=8, HALF_PERIOD=5, BURST_CYCLES=3, PERIOD_CYCLES=200.

- Steer right: sin=64, sign=0, repeat_en=0. Required response:
  - offsets 0, 4, 8, 12;
  - tx_out[2] high for t = 8..12, 18..22, 28..32;
  - tx_active high for t = 0..41, then IDLE.
- Steer left: sin=64, sign=1. Offsets must be 12, 8, 4, 0, with tx_out[3] rising at t=0 and tx_out[0] rising at t=12.
- Zero angle: sin=0. All four channels must be identical, with exactly 3 pulses of 5 high cycles each and a 30-cycle burst.
- Saturation: DELAY_WIDTH=5, sin=255, sign=0. off_3 must be 31, not 47; off_1 = 15, off_2 = 31; the burst ends at t=60.
- Repeat: repeat_en held 1, sin changed from 64 to 32 mid-burst. Required response:
  - burst_start pulses exactly 200 cycles apart;
  - the second burst uses offsets 0, 2, 4, 6;
  - dropping repeat_en returns the block to IDLE after the current burst.
- Abort and reset: abort at t=7 must give tx_out=0 and busy=0 on the next cycle, and a start asserted in the same cycle must be ignored. rst_in low mid-BURST must give all outputs 0 immediately, with a clean restart on the next start.
